// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) bus initiator, one full-duplex DATA_WIDTH-bit frame per accepted start.
// Build macro SPI_MASTER_LSB_FIRST_EN selects LSB-first bit order; left undefined the frame is MSB first.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [HALF_W-1:0] HALF_ZERO = HALF_W'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_r,    state_s;
  logic [DIV_W-1:0]      div_cnt_r,  div_cnt_s;
  logic [HALF_W-1:0]     half_cnt_r, half_cnt_s;
  logic [DATA_WIDTH-1:0] shift_r,    shift_s;
  logic [DATA_WIDTH-1:0] rx_data_r,  rx_data_s;
  logic                  ready_r,    ready_s;
  logic                  rx_valid_r, rx_valid_s;
  logic                  cs_r,       cs_s;
  logic                  sck_r,      sck_s;
  logic                  mosi_r,     mosi_s;
  logic                  div_wrap_s;

  // The shift register serves both directions: the outgoing bit sits at the head,
  // received bits enter at the tail, so after DATA_WIDTH shifts it holds the rx word.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_WIDTH-1];
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic                  b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {b, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], b};
`endif
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    half_cnt_s = half_cnt_r;
    shift_s    = shift_r;
    rx_data_s  = rx_data_r;
    ready_s    = ready_r;
    rx_valid_s = 1'b0;
    cs_s       = cs_r;
    sck_s      = sck_r;
    mosi_s     = mosi_r;
    div_wrap_s = (div_cnt_r == DIV_LAST);

    case (state_r)
      IDLE: begin
        div_cnt_s  = DIV_ZERO;
        half_cnt_s = HALF_ZERO;
        if (start) begin
          state_s = SETUP;
          shift_s = tx_data;
          mosi_s  = head_bit(tx_data);
          cs_s    = 1'b0;
          ready_s = 1'b0;
        end else begin
          cs_s    = 1'b1;
          ready_s = 1'b1;
          sck_s   = 1'b0;
          mosi_s  = 1'b0;
        end
      end

      SETUP: begin
        if (div_wrap_s) begin
          state_s   = XFER;
          div_cnt_s = DIV_ZERO;
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end

      // Each half-period ends with an sck toggle; the final toggle is a falling edge.
      XFER: begin
        if (div_wrap_s) begin
          div_cnt_s = DIV_ZERO;
          sck_s     = ~sck_r;
          if (!sck_r) begin
            shift_s = shift_in(shift_r, miso);
          end else if (half_cnt_r != HALF_LAST) begin
            mosi_s = head_bit(shift_r);
          end else begin
            mosi_s = mosi_r;
          end
          if (half_cnt_r == HALF_LAST) begin
            state_s    = HOLD;
            half_cnt_s = HALF_ZERO;
          end else begin
            half_cnt_s = half_cnt_r + HALF_ONE;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end

      HOLD: begin
        if (div_wrap_s) begin
          state_s    = DONE;
          div_cnt_s  = DIV_ZERO;
          cs_s       = 1'b1;
          mosi_s     = 1'b0;
          rx_data_s  = shift_r;
          rx_valid_s = 1'b1;
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end

      DONE: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end

      default: begin
        state_s    = IDLE;
        div_cnt_s  = DIV_ZERO;
        half_cnt_s = HALF_ZERO;
        ready_s    = 1'b1;
        cs_s       = 1'b1;
        sck_s      = 1'b0;
        mosi_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      div_cnt_r  <= DIV_ZERO;
      half_cnt_r <= HALF_ZERO;
      shift_r    <= {DATA_WIDTH{1'b0}};
      rx_data_r  <= {DATA_WIDTH{1'b0}};
      ready_r    <= 1'b1;
      rx_valid_r <= 1'b0;
      cs_r       <= 1'b1;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      half_cnt_r <= half_cnt_s;
      shift_r    <= shift_s;
      rx_data_r  <= rx_data_s;
      ready_r    <= ready_s;
      rx_valid_r <= rx_valid_s;
      cs_r       <= cs_s;
      sck_r      <= sck_s;
      mosi_r     <= mosi_s;
    end
  end

  assign ready    = ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign cs       = cs_r;
  assign sck      = sck_r;
  assign mosi     = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master with loopback and shift-register slave models.
module tb_spi_master;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int LAT = (2 * DW + 2) * DIV + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] tx_data;
  logic          ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          cs;
  logic          sck;
  logic          mosi;
  logic          miso;

  logic          loop_en;
  logic [DW-1:0] slave_word;
  logic [DW-1:0] slave_sr;
  logic          slave_bit;

  typedef struct packed {
    logic [DW-1:0] rx;
    logic [DW-1:0] tx;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          exp_e;
  int            n_checks = 0;
  int            n_errors = 0;
  int            valid_cnt = 0;
  int            cyc_cnt = 0;
  int            rise_cnt = 0;
  int            cs_low_cnt = 0;
  logic          sck_q = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] mosi_cap = '0;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .ready    (ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cs       (cs),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: first bit presented when cs falls, next bit on each sck falling edge.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign slave_bit = slave_sr[0];
  always @(negedge sck) if (!cs) slave_sr = {1'b0, slave_sr[DW-1:1]};
`else
  assign slave_bit = slave_sr[DW-1];
  always @(negedge sck) if (!cs) slave_sr = {slave_sr[DW-2:0], 1'b0};
`endif
  always @(negedge cs) slave_sr = slave_word;
  assign miso = loop_en ? mosi : slave_bit;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling clk edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cyc_cnt    = 0;
      rise_cnt   = 0;
      cs_low_cnt = 0;
      sck_q      = 1'b0;
      prev_valid = 1'b0;
    end else begin
      cyc_cnt++;
      if (!cs) cs_low_cnt++;
      if (sck && !sck_q) begin
        rise_cnt++;
`ifdef SPI_MASTER_LSB_FIRST_EN
        mosi_cap = {mosi, mosi_cap[DW-1:1]};
`else
        mosi_cap = {mosi_cap[DW-2:0], mosi};
`endif
      end
      sck_q = sck;
      if (prev_valid) begin
        check_val("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
        check_val("ready_after_valid", 32'(ready), 32'd1);
      end
      prev_valid = rx_valid;
      if (rx_valid) begin
        valid_cnt++;
        check_val("pending_frame", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check_val("rx_data", 32'(rx_data), 32'(exp_e.rx));
          check_val("latency", 32'(cyc_cnt), 32'(LAT));
          check_val("sck_rises", 32'(rise_cnt), 32'(DW));
          check_val("cs_low_clks", 32'(cs_low_cnt), 32'(LAT - 1));
          check_val("mosi_bits", 32'(mosi_cap), 32'(exp_e.tx));
          check_val("done_cs", 32'(cs), 32'd1);
          check_val("done_ready", 32'(ready), 32'd0);
        end
      end
      if (ready && start) begin
        exp_e.tx = tx_data;
        exp_e.rx = loop_en ? tx_data : slave_word;
        exp_q.push_back(exp_e);
        cyc_cnt    = 0;
        rise_cnt   = 0;
        cs_low_cnt = 0;
        mosi_cap   = '0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    @(posedge clk); #1;
    tx_data = d;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_valid(input int target, input string tag);
    for (int i = 0; i < 4 * LAT && valid_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    check_val(tag, 32'(valid_cnt), 32'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    int v;
    int hi;
    rst        = 1'b1;
    start      = 1'b0;
    tx_data    = '0;
    loop_en    = 1'b1;
    slave_word = '0;
    slave_sr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ready", 32'(ready), 32'd1);
    check_val("reset_rx_data", 32'(rx_data), 32'd0);
    check_val("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_val("reset_cs", 32'(cs), 32'd1);
    check_val("reset_sck", 32'(sck), 32'd0);
    check_val("reset_mosi", 32'(mosi), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loopback 0xA5.
    v = valid_cnt;
    send(8'hA5);
    wait_valid(v + 1, "frame_a5");

    // Slave returns 0x3C while master sends 0x00.
    loop_en    = 1'b0;
    slave_word = 8'h3C;
    v = valid_cnt;
    send(8'h00);
    wait_valid(v + 1, "frame_3c");

    // Mid-frame start with 0xFF must be ignored.
    loop_en = 1'b1;
    v = valid_cnt;
    send(8'hC3);
    repeat (20) @(posedge clk);
    #1;
    tx_data = 8'hFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_valid(v + 1, "frame_c3");
    repeat (LAT) @(posedge clk);
    #1;
    check_val("single_rx_valid", 32'(valid_cnt), 32'(v + 1));

    // Reset one clk after the 3rd sck rising edge.
    v = valid_cnt;
    send(8'h96);
    for (int i = 0; i < 2 * LAT && rise_cnt < 3; i++) begin
      @(posedge clk); #1;
    end
    check_val("third_rise_seen", 32'(rise_cnt), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_cs", 32'(cs), 32'd1);
    check_val("abort_sck", 32'(sck), 32'd0);
    check_val("abort_mosi", 32'(mosi), 32'd0);
    check_val("abort_ready", 32'(ready), 32'd1);
    check_val("abort_rx_data", 32'(rx_data), 32'd0);
    check_val("abort_rx_valid", 32'(rx_valid), 32'd0);
    repeat (2 * LAT) @(posedge clk);
    #1;
    check_val("abort_no_valid", 32'(valid_cnt), 32'(v));

    // Back-to-back frames with start held high.
    v = valid_cnt;
    @(posedge clk); #1;
    tx_data = 8'h12;
    start   = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h34;
    for (int i = 0; i < 2 * LAT && rx_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    hi = 0;
    for (int i = 0; i < 10 && cs === 1'b1; i++) begin
      hi++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_val("b2b_cs_high", 32'(hi), 32'd2);
    wait_valid(v + 2, "b2b_frames");

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB first: 0x01 goes out as 1 then seven 0s.
    v = valid_cnt;
    send(8'h01);
    wait_valid(v + 1, "frame_lsb_01");
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
